psum_fifo: RTL and testbench
============================

// Module: psum_fifo
// PURPOSE
//  First-word-fall-through FIFO carrying partial sums between vertically adjacent PEs.
//  Upstream PE writes through opsum_pixel/push_opsum and reads opsum_fifo_full.
//  Downstream PE reads through ipsum_pixel/pop_ipsum and reads ipsum_fifo_empty.
//  The head word is visible combinationally, so the consumer samples dout in the same cycle it asserts pop.
// PARAMETERS
//  DATA_WIDTH    16  psum word width
//  DEPTH         16  number of entries; any value >= 2, not required to be a power of two
//  AFULL_THRESH  12  almost_full asserts when count >= AFULL_THRESH
//  CNT_WIDTH     $clog2(DEPTH+1), localparam; width of count
// PORTS
//  clk          in   1           rising-edge clock
//  reset        in   1           synchronous, active-high
//  din          in   DATA_WIDTH  write data from upstream opsum_pixel
//  push         in   1           write request from upstream push_opsum
//  full         out  1           count == DEPTH
//  almost_full  out  1           count >= AFULL_THRESH
//  dout         out  DATA_WIDTH  head word; 0 while empty
//  pop          in   1           read request from downstream pop_ipsum
//  empty        out  1           count == 0
//  count        out  CNT_WIDTH   current occupancy
//  overflow     out  1           sticky: a push was dropped
//  underflow    out  1           sticky: a pop arrived while empty
//  clear_err    in   1           clears overflow, underflow and high_water
//  high_water   out  CNT_WIDTH   peak occupancy (feature-gated, see CONFIGURATION)
// BEHAVIOUR
//  - Reset
//    - rd_ptr, wr_ptr and count go to 0.
//    - empty=1, full=0, almost_full=0, dout=0.
//    - overflow=0, underflow=0, high_water=0.
//    - Storage contents are not reset.
//  - Write: push && !full writes din to mem[wr_ptr] at the clock edge. wr_ptr increments and wraps from DEPTH-1 to 0.
//  - Read: pop && !empty retires the head at the clock edge. rd_ptr increments and wraps from DEPTH-1 to 0.
//    - dout is valid in the pop cycle (0 latency).
//    - The next entry appears on dout the following cycle.
//  - Write-to-read latency is 1 cycle: a word pushed into an empty FIFO appears on dout, with empty=0, the next cycle.
//    There is no same-cycle bypass.
//  - Simultaneous push and pop, count unchanged:
//    - Both succeed when 0 < count < DEPTH.
//    - When full: the pop succeeds and the push is also accepted, because a slot is freed in the same edge. overflow is not set.
//    - When empty: the push is accepted, the pop is ignored, and underflow is set.
//  - Errors
//    - push && full && !pop: din is dropped, state is unchanged, overflow sets to 1.
//    - pop && empty: nothing changes except underflow sets to 1.
//    - Both flags hold until reset or clear_err.
//    - If clear_err coincides with a new error event, the error wins and the flag stays 1.
//  - Flags are registered-state derived: full, empty and almost_full are combinational from count only. Never from push or pop.
//  - count update: count_next = count + (push accepted) - (pop accepted). count never exceeds DEPTH and never goes below 0.
//  - Reset mid-operation discards all contents. The FIFO reads empty in the cycle after reset.
// CONFIGURATION
//  - PSUM_FIFO_HIGH_WATER_EN
//    - Defined: high_water registers the maximum count_next seen since reset or clear_err.
//      On clear_err it loads the current count_next instead of 0.
//    - Not defined: high_water is tied to 0 and no register is built. The port stays present.
// TESTING
//  - Fill then drain: push 0x0001..0x0010 on 16 consecutive cycles (DEPTH=16).
//    Required: full=1, almost_full from count 12, count=16.
//    Then 16 pops: dout reads 0x0001..0x0010 in order, empty=1, overflow=0.
//  - Overflow: at full, push 0xBEEF without pop.
//    Required: count stays 16, overflow=1, next 16 pops never return 0xBEEF.
//    clear_err -> overflow=0.
//  - Underflow with simultaneous push: empty, push 0x1234 and pop in the same cycle.
//    Required: underflow=1, count=1, dout=0x1234 the next cycle.
//  - Full push+pop: at full, push 0x00AA and pop together for 20 cycles.
//    Required: count stays 16, no overflow, pointers wrap, FIFO order is preserved across the wrap.
//  - Mid-operation reset: count=7, assert reset for 1 cycle.
//    Required: empty=1, count=0, dout=0, flags cleared.
//    A push of 0x0055 then appears on dout 1 cycle later.
//  - High water (macro on): push 9, pop 5, push 2.
//    Required: high_water=9. clear_err -> high_water=6.
//    Macro off: high_water==0 throughout.

Source files
------------

// File: rtl/psum_fifo.sv
// psum_fifo: first-word-fall-through FIFO carrying partial sums between
// vertically adjacent PEs. The head word is presented combinationally on
// dout, so the consumer samples it in the same cycle it raises pop.
// A word pushed into an empty FIFO becomes visible on the following cycle;
// there is no same-cycle bypass from din to dout.
//
// Optional feature macro: PSUM_FIFO_HIGH_WATER_EN
//   defined     - high_water tracks peak occupancy since reset / clear_err
//   not defined - high_water is tied to zero and no register is built
module psum_fifo #(
  parameter int DATA_WIDTH   = 16,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12,
  localparam int CNT_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  push,
  output logic                  full,
  output logic                  almost_full,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic                  pop,
  output logic                  empty,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clear_err,
  output logic [CNT_WIDTH-1:0]  high_water
);

  // Pointer width covers indices 0..DEPTH-1; DEPTH need not be a power of two.
  localparam int PTR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_WIDTH-1:0] LAST_IDX = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  logic [PTR_WIDTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_WIDTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CNT_WIDTH-1:0] count_reg, count_next;
  logic                 overflow_reg, overflow_next;
  logic                 underflow_reg, underflow_next;

  logic push_ok;
  logic pop_ok;
  logic overflow_evt;
  logic underflow_evt;

  // Status flags come from registered occupancy only, never from push/pop.
  assign empty       = (count_reg == '0);
  assign full        = (count_reg == DEPTH_CNT);
  assign almost_full = (int'(count_reg) >= AFULL_THRESH);
  assign count       = count_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;

  // Head word falls through; forced to zero while nothing is stored.
  assign dout = empty ? '0 : mem[rd_ptr_reg];

  // A pop is honoured whenever data exists. A push is honoured when there is
  // room, or when the FIFO is full but a pop frees a slot on the same edge.
  assign pop_ok        = pop && !empty;
  assign push_ok       = push && (!full || pop_ok);
  assign overflow_evt  = push && !push_ok;
  assign underflow_evt = pop && empty;

  // Next-state for pointers, occupancy and sticky error flags.
  always_comb begin
    rd_ptr_next    = rd_ptr_reg;
    wr_ptr_next    = wr_ptr_reg;
    count_next     = count_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;

    if (push_ok) begin
      wr_ptr_next = (wr_ptr_reg == LAST_IDX) ? '0 : wr_ptr_reg + PTR_WIDTH'(1);
    end
    if (pop_ok) begin
      rd_ptr_next = (rd_ptr_reg == LAST_IDX) ? '0 : rd_ptr_reg + PTR_WIDTH'(1);
    end

    case ({push_ok, pop_ok})
      2'b10:   count_next = count_reg + CNT_WIDTH'(1);
      2'b01:   count_next = count_reg - CNT_WIDTH'(1);
      default: count_next = count_reg;
    endcase

    // A fresh error on the same cycle as clear_err keeps the flag set.
    if (overflow_evt) begin
      overflow_next = 1'b1;
    end else if (clear_err) begin
      overflow_next = 1'b0;
    end
    if (underflow_evt) begin
      underflow_next = 1'b1;
    end else if (clear_err) begin
      underflow_next = 1'b0;
    end
  end

  // Control state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg    <= '0;
      wr_ptr_reg    <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      rd_ptr_reg    <= rd_ptr_next;
      wr_ptr_reg    <= wr_ptr_next;
      count_reg     <= count_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  // Storage write; contents are intentionally left unreset. A push landing
  // in the same cycle as reset is harmless because the pointers clear.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr_reg] <= din;
    end
  end

`ifdef PSUM_FIFO_HIGH_WATER_EN
  logic [CNT_WIDTH-1:0] high_water_reg;

  // Peak occupancy tracker; clear_err restarts it from the upcoming count.
  always_ff @(posedge clk) begin
    if (reset) begin
      high_water_reg <= '0;
    end else if (clear_err) begin
      high_water_reg <= count_next;
    end else if (count_next > high_water_reg) begin
      high_water_reg <= count_next;
    end
  end

  assign high_water = high_water_reg;
`else
  assign high_water = '0;
`endif

endmodule

// File: tb/tb_psum_fifo.sv
// tb_psum_fifo: directed table vectors plus hand-written multi-cycle
// sequences for the psum_fifo block (DEPTH=16, AFULL_THRESH=12).
module tb_psum_fifo;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic [DW-1:0] din;
  logic          push;
  logic          full;
  logic          almost_full;
  logic [DW-1:0] dout;
  logic          pop;
  logic          empty;
  logic [CW-1:0] count;
  logic          overflow;
  logic          underflow;
  logic          clear_err;
  logic [CW-1:0] high_water;

  int n_checks = 0;
  int n_bad    = 0;

  psum_fifo #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .AFULL_THRESH(12)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .din        (din),
    .push       (push),
    .full       (full),
    .almost_full(almost_full),
    .dout       (dout),
    .pop        (pop),
    .empty      (empty),
    .count      (count),
    .overflow   (overflow),
    .underflow  (underflow),
    .clear_err  (clear_err),
    .high_water (high_water)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          push;
    logic          pop;
    logic          clr;
    logic [DW-1:0] din;
    int            cnt;
    logic [DW-1:0] dout;
    logic          empty;
    logic          ovf;
    logic          udf;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h want=%h at t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock edge; outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
    $display("t=%0t push=%b pop=%b clr=%b din=%h -> count=%0d dout=%h e=%b f=%b af=%b ovf=%b udf=%b hw=%0d",
             $time, push, pop, clear_err, din, count, dout, empty, full, almost_full,
             overflow, underflow, high_water);
  endtask

  task automatic idle();
    push = 1'b0; pop = 1'b0; clear_err = 1'b0; din = '0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  logic [DW-1:0] q [$];
  logic [DW-1:0] head;
  int            exp_hw;

  initial begin
    reset = 1'b1;
    idle();
    step();
    step();
    reset = 1'b0;

    // Reset state
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_count", count, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_udf", underflow, 0);
    chk("rst_hw", high_water, 0);

    // Table: push, pop, clr, din | count, dout, empty, ovf, udf
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 1, 16'h1234, 1'b0, 1'b0, 1'b1}; // push+pop on empty
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h0011, 1, 16'h0011, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, 16'h0022, 1, 16'h0022, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b0, 16'h0033, 2, 16'h0022, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 1, 16'h0033, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h0000, 1'b1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 0, 16'h0000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 16'h0000, 0, 16'h0000, 1'b1, 1'b0, 1'b1}; // error beats clear
    vecs[10] = '{1'b0, 1'b0, 1'b1, 16'h0000, 0, 16'h0000, 1'b1, 1'b0, 1'b0};

    for (int i = 0; i < 11; i++) begin
      push = vecs[i].push; pop = vecs[i].pop; clear_err = vecs[i].clr; din = vecs[i].din;
      step();
      idle();
      chk($sformatf("vec%0d_count", i), count, vecs[i].cnt);
      chk($sformatf("vec%0d_dout", i), dout, vecs[i].dout);
      chk($sformatf("vec%0d_empty", i), empty, vecs[i].empty);
      chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].ovf);
      chk($sformatf("vec%0d_udf", i), underflow, vecs[i].udf);
    end

    // Fill then drain
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; din = DW'(i + 1);
      step();
      chk($sformatf("fill%0d_count", i), count, i + 1);
      chk($sformatf("fill%0d_afull", i), almost_full, (i + 1 >= 12) ? 1 : 0);
      chk($sformatf("fill%0d_full", i), full, (i + 1 == 16) ? 1 : 0);
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("drain%0d_dout", i), dout, i + 1);
      pop = 1'b1;
      step();
      idle();
    end
    chk("drain_empty", empty, 1);
    chk("drain_count", count, 0);
    chk("drain_ovf", overflow, 0);

    // Overflow: refill, push 0xBEEF at full without a pop
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; din = DW'(16'h0101 + i);
      step();
    end
    push = 1'b1; din = 16'hBEEF;
    step();
    idle();
    chk("ovf_count", count, 16);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("ovf_drain%0d_dout", i), dout, 16'h0101 + i);
      pop = 1'b1;
      step();
      idle();
    end
    chk("ovf_drain_empty", empty, 1);
    clear_err = 1'b1;
    step();
    idle();
    chk("ovf_cleared", overflow, 0);

    // Full push+pop for 20 cycles, order checked across pointer wrap
    q.delete();
    for (int i = 0; i < 16; i++) begin
      push = 1'b1; din = DW'(16'h0201 + i);
      q.push_back(din);
      step();
    end
    idle();
    for (int j = 0; j < 20; j++) begin
      head = q.pop_front();
      chk($sformatf("pp%0d_dout", j), dout, head);
      push = 1'b1; pop = 1'b1; din = DW'(16'h00AA + j);
      q.push_back(din);
      step();
      idle();
      chk($sformatf("pp%0d_count", j), count, 16);
    end
    chk("pp_ovf", overflow, 0);
    chk("pp_full", full, 1);
    for (int i = 0; i < 16; i++) begin
      head = q.pop_front();
      chk($sformatf("pp_drain%0d_dout", i), dout, head);
      pop = 1'b1;
      step();
      idle();
    end
    chk("pp_drain_empty", empty, 1);

    // Mid-operation reset with count=7 and an underflow flag pending
    pop = 1'b1;
    step();
    idle();
    chk("mid_udf_set", underflow, 1);
    for (int i = 0; i < 7; i++) begin
      push = 1'b1; din = DW'(16'h0300 + i);
      step();
    end
    idle();
    chk("mid_count7", count, 7);
    do_reset();
    chk("mid_empty", empty, 1);
    chk("mid_count", count, 0);
    chk("mid_dout", dout, 0);
    chk("mid_udf", underflow, 0);
    chk("mid_ovf", overflow, 0);
    chk("mid_afull", almost_full, 0);
    push = 1'b1; din = 16'h0055;
    step();
    idle();
    chk("mid_push_dout", dout, 16'h0055);
    chk("mid_push_count", count, 1);

    // High water: push 9, pop 5, push 2, then clear_err
    do_reset();
`ifdef PSUM_FIFO_HIGH_WATER_EN
    exp_hw = 9;
`else
    exp_hw = 0;
`endif
    for (int i = 0; i < 9; i++) begin
      push = 1'b1; din = DW'(i);
      step();
    end
    idle();
    for (int i = 0; i < 5; i++) begin
      pop = 1'b1;
      step();
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      push = 1'b1; din = DW'(16'h0400 + i);
      step();
    end
    idle();
    chk("hw_count", count, 6);
    chk("hw_peak", high_water, exp_hw);
    clear_err = 1'b1;
    step();
    idle();
`ifdef PSUM_FIFO_HIGH_WATER_EN
    exp_hw = 6;
`else
    exp_hw = 0;
`endif
    chk("hw_after_clear", high_water, exp_hw);
    chk("hw_dout", dout, 16'h0005);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
